// File: rtl/npc_ras_unit.sv
`default_nettype none
//==============================================================================
// Module   : npc_ras_unit
// Brief    : F-stage PC register and next-PC select for the 5-stage MIPS
//            pipeline, with a circular return-address stack that lets
//            jr $31 redirect before rs has been forwarded.
//            Optional feature macro: NPC_EXC_EN (exception entry and eret).
// Revision : 1.0 - initial release
//==============================================================================
module npc_ras_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       NPC_op,
    input  logic [PC_W-1:0]  D_pc,
    input  logic [31:0]      instr_offset_ext,
    input  logic [25:0]      instr_index,
    input  logic [PC_W-1:0]  pc_rs,
    input  logic             rs_ready,
    input  logic             rs_is_ra,
    input  logic             judge_b,
    input  logic             exc_req,
    input  logic [PC_W-1:0]  epc,
    output logic [PC_W-1:0]  F_pc,
    output logic [PC_W-1:0]  npc,
    output logic             stall_req,
    output logic             ras_used,
    output logic [4:0]       ras_cnt
);

    localparam int         c_PTR_W   = $clog2(RAS_DEPTH);
    localparam int         c_CNT_W   = c_PTR_W + 1;
    localparam logic [2:0] c_OP_ORDER = 3'b000;
    localparam logic [2:0] c_OP_BTYPE = 3'b001;
    localparam logic [2:0] c_OP_JAL   = 3'b010;
    localparam logic [2:0] c_OP_JR    = 3'b011;
    localparam logic [2:0] c_OP_ERET  = 3'b100;

    logic [PC_W-1:0]    r_fpc;
    logic [PC_W-1:0]    r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_cnt;

    logic [PC_W-1:0]    w_seq;
    logic [PC_W-1:0]    w_br;
    logic [PC_W-1:0]    w_jal;
    logic [PC_W-1:0]    w_link;
    logic [31:0]        w_off32;
    logic [PC_W-1:0]    w_off_sh;
    logic [PC_W-1:0]    w_npc;
    logic               w_stall;
    logic               w_used;
    logic               w_exc;
    logic               w_adv;
    logic               w_fpc_we;
    logic               w_ras_we;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_push_idx;

    // Exception inputs are live only when the feature is built in.
`ifdef NPC_EXC_EN
    assign w_exc = exc_req;
`else
    logic w_unused_exc;
    assign w_exc        = 1'b0;
    assign w_unused_exc = ^{exc_req, epc, EXC_VECTOR};
`endif

    // Word offset brought to PC width, sign preserved on wide PCs.
    assign w_off32 = instr_offset_ext << 2;
    generate
        if (PC_W > 32) begin : g_off_wide
            assign w_off_sh = {{(PC_W-32){instr_offset_ext[31]}}, w_off32};
        end else begin : g_off_narrow
            assign w_off_sh = w_off32[PC_W-1:0];
        end
    endgenerate

    assign w_seq  = r_fpc + PC_W'(4);
    assign w_br   = D_pc + PC_W'(4) + w_off_sh;
    assign w_jal  = {D_pc[PC_W-1:28], instr_index, 2'b00};
    assign w_link = D_pc + PC_W'(8);

    always_comb begin
        w_npc   = w_seq;
        w_stall = 1'b0;
        w_used  = 1'b0;
        if (w_exc) begin
            w_npc = EXC_VECTOR;
        end else begin
            case (NPC_op)
`ifdef NPC_EXC_EN
                c_OP_ERET:  w_npc = epc;
`endif
                c_OP_BTYPE: w_npc = judge_b ? w_br : w_seq;
                c_OP_JAL:   w_npc = w_jal;
                c_OP_JR: begin
                    if (rs_ready) begin
                        w_npc = pc_rs;
                    end else if (rs_is_ra && (r_cnt != '0)) begin
                        w_npc  = r_ras[r_top];
                        w_used = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default:    w_npc = w_seq;
            endcase
        end
    end

    assign w_adv      = en && !w_stall;
    assign w_fpc_we   = w_adv || w_exc;
    assign w_ras_we   = w_adv && !w_exc;
    assign w_push     = w_ras_we && (NPC_op == c_OP_JAL);
    // A jr $31 consumes its entry even when the forwarded rs was used.
    assign w_pop      = w_ras_we && (NPC_op == c_OP_JR) && rs_is_ra && (r_cnt != '0);
    assign w_push_idx = r_top + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc <= RESET_PC;
        end else if (w_fpc_we) begin
            r_fpc <= w_npc;
        end
    end

    // Circular stack: a push when full lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[w_push_idx] <= w_link;
            r_top             <= w_push_idx;
            if (r_cnt != c_CNT_W'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else if (w_pop) begin
            r_top <= r_top - c_PTR_W'(1);
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign F_pc      = r_fpc;
    assign npc       = w_npc;
    assign stall_req = w_stall;
    assign ras_used  = w_used;
    assign ras_cnt   = 5'(r_cnt);

    // Unused op encodings fall through to sequential fetch.
    logic w_unused_ops;
    assign w_unused_ops = ^{c_OP_ORDER, c_OP_ERET};

endmodule
`default_nettype wire

// File: tb/tb_npc_ras_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_npc_ras_unit
// Brief    : Scoreboard bench for npc_ras_unit against a queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_npc_ras_unit;

    localparam int          PC_W       = 32;
    localparam int          RAS_DEPTH  = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
`ifdef NPC_EXC_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  NPC_op;
    logic [31:0] D_pc;
    logic [31:0] instr_offset_ext;
    logic [25:0] instr_index;
    logic [31:0] pc_rs;
    logic        rs_ready;
    logic        rs_is_ra;
    logic        judge_b;
    logic        exc_req;
    logic [31:0] epc;
    logic [31:0] F_pc;
    logic [31:0] npc;
    logic        stall_req;
    logic        ras_used;
    logic [4:0]  ras_cnt;

    npc_ras_unit #(
        .PC_W       (PC_W),
        .RESET_PC   (RESET_PC),
        .RAS_DEPTH  (RAS_DEPTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .en               (en),
        .NPC_op           (NPC_op),
        .D_pc             (D_pc),
        .instr_offset_ext (instr_offset_ext),
        .instr_index      (instr_index),
        .pc_rs            (pc_rs),
        .rs_ready         (rs_ready),
        .rs_is_ra         (rs_is_ra),
        .judge_b          (judge_b),
        .exc_req          (exc_req),
        .epc              (epc),
        .F_pc             (F_pc),
        .npc              (npc),
        .stall_req        (stall_req),
        .ras_used         (ras_used),
        .ras_cnt          (ras_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] npc;
        logic        stall;
        logic        used;
        logic [4:0]  cnt;
    } exp_t;

    exp_t        exp_q [$];
    int          checks   = 0;
    int          failures = 0;

    // Reference state: fetch PC and a return-address list, newest at the back.
    logic [31:0] m_fpc;
    logic [31:0] m_ras [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("F_pc",      F_pc,              e.fpc);
            check("npc",       npc,               e.npc);
            check("stall_req", {31'd0, stall_req}, {31'd0, e.stall});
            check("ras_used",  {31'd0, ras_used},  {31'd0, e.used});
            check("ras_cnt",   {27'd0, ras_cnt},   {27'd0, e.cnt});
        end
    end

    task automatic cyc(input logic [2:0] op, input logic [31:0] dpc, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] prs, input logic rdy,
                       input logic isra, input logic jb, input logic exc, input logic [31:0] ep,
                       input logic e_n, input logic rst);
        exp_t        x;
        logic        take_exc;
        NPC_op = op; D_pc = dpc; instr_offset_ext = off; instr_index = idx;
        pc_rs = prs; rs_ready = rdy; rs_is_ra = isra; judge_b = jb;
        exc_req = exc; epc = ep; en = e_n; reset = rst;

        take_exc = EXC_ON && exc;
        x.fpc   = m_fpc;
        x.cnt   = 5'(m_ras.size());
        x.stall = 1'b0;
        x.used  = 1'b0;
        x.npc   = m_fpc + 32'd4;
        if (take_exc)                     x.npc = EXC_VECTOR;
        else if (op == 3'd4 && EXC_ON)    x.npc = ep;
        else if (op == 3'd1 && jb)        x.npc = dpc + 32'd4 + (off << 2);
        else if (op == 3'd2)              x.npc = {dpc[31:28], idx, 2'b00};
        else if (op == 3'd3) begin
            if (rdy)                               x.npc = prs;
            else if (isra && m_ras.size() > 0) begin x.npc = m_ras[$]; x.used = 1'b1; end
            else                                   x.stall = 1'b1;
        end
        exp_q.push_back(x);

        if (rst) begin
            m_fpc = RESET_PC;
            m_ras.delete();
        end else begin
            if ((e_n && !x.stall) || take_exc) m_fpc = x.npc;
            if (e_n && !x.stall && !take_exc) begin
                if (op == 3'd2) begin
                    m_ras.push_back(dpc + 32'd8);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end else if (op == 3'd3 && isra && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] o16;
        int          r;
        logic [2:0]  op;
        NPC_op = 3'd0; D_pc = '0; instr_offset_ext = '0; instr_index = '0;
        pc_rs = '0; rs_ready = 1'b0; rs_is_ra = 1'b0; judge_b = 1'b0;
        exc_req = 1'b0; epc = '0; en = 1'b0; reset = 1'b1;
        m_fpc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;

        // Sequential fetch from reset, then branches taken/not taken.
        repeat (4) cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(3'd1, 32'h3010, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc(3'd1, 32'h3010, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Push, pop from RAS, then stall on empty until rs arrives.
        cyc(3'd2, 32'h3020, 0, 26'h0000C00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 32'h3400, 1, 1, 0, 0, 0, 1, 0);
        cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Overflow: five pushes into four slots, then five pops.
        for (int k = 0; k < 5; k++)
            cyc(3'd2, 32'h3000 + 32'(16 * k), 0, 26'h0000C00, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++)
            cyc(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Exception entry with the pipeline frozen, then eret.
        cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3100, 1, 0);
        cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset asserted while stalled.
        cyc(3'd2, 32'h3050, 0, 26'h0000D00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd3 : 3'(4 + $urandom_range(0, 3));
            o16 = 16'($urandom);
            cyc(op, 32'h3000 + 32'($urandom_range(0, 255) << 2), {{16{o16[15]}}, o16},
                26'($urandom), 32'h3000 + 32'($urandom_range(0, 255) << 2),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0), 32'h3000 + 32'($urandom_range(0, 255) << 2),
                ($urandom_range(0, 4) != 0), ($urandom_range(0, 199) == 0));
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
